// File: rtl/fetch_lsu_arbiter_pkg.sv
// Shared types for the IFU/LSU bus arbiter: FSM state encoding and bus-owner codes.
package fetch_lsu_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IFU  = 2'd1,
    ARB_LSU  = 2'd2
  } arb_state_t;

  localparam logic OWNER_IFU = 1'b0;
  localparam logic OWNER_LSU = 1'b1;

  // Owner code presented on BusOwner; idle reports the IFU code (BusReq is low then).
  function automatic logic owner_of(arb_state_t s);
    return (s == ARB_LSU) ? OWNER_LSU : OWNER_IFU;
  endfunction

endpackage

// File: rtl/fetch_lsu_arbiter_if.sv
// Request/grant/bus signal bundle between the IFU, LSU, arbiter and bus adapter.
interface fetch_lsu_arbiter_if #(
  parameter int XLEN = 64
) ();

  logic            IFUReq;
  logic [XLEN-1:0] IFUAdr;
  logic            IFUSpillLock;
  logic            IFUGnt;
  logic            IFUDone;

  logic            LSUReq;
  logic [XLEN-1:0] LSUAdr;
  logic            LSUWrite;
  logic            LSUAtomicLock;
  logic            LSUGnt;
  logic            LSUDone;

  logic            BusReq;
  logic [XLEN-1:0] BusAdr;
  logic            BusWrite;
  logic            BusOwner;
  logic            BusDone;

  // Arbiter side
  modport slave (
    input  IFUReq, IFUAdr, IFUSpillLock,
    input  LSUReq, LSUAdr, LSUWrite, LSUAtomicLock,
    input  BusDone,
    output IFUGnt, IFUDone, LSUGnt, LSUDone,
    output BusReq, BusAdr, BusWrite, BusOwner
  );

  // Requester / bus-adapter side
  modport master (
    output IFUReq, IFUAdr, IFUSpillLock,
    output LSUReq, LSUAdr, LSUWrite, LSUAtomicLock,
    output BusDone,
    input  IFUGnt, IFUDone, LSUGnt, LSUDone,
    input  BusReq, BusAdr, BusWrite, BusOwner
  );

endinterface

// File: rtl/fetch_lsu_arbiter_starve_ctr.sv
// Saturating IFU wait counter; fired is high while the count sits at LIMIT.
module arb_starve_ctr
  import fetch_lsu_arbiter_pkg::*;
#(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic inc,
  input  logic clr,
  output logic fired
);

  localparam int            W   = $clog2(LIMIT + 1);
  localparam logic [W-1:0]  MAX = W'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins over increment: the grant edge always restarts the wait.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fired = (cnt_q == MAX);

endmodule

// File: rtl/fetch_lsu_arbiter.sv
// IFU/LSU bus arbiter with spill/atomic ownership lock and LSU-first priority.
// Define ARB_STARVE_GUARD_EN to bound IFU wait time behind the LSU (STARVE_LIMIT cycles).
module fetch_lsu_arbiter
  import fetch_lsu_arbiter_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  fetch_lsu_arbiter_if.slave  bus
);

  if (STARVE_LIMIT < 1) begin : g_limit_check
    $error("STARVE_LIMIT must be at least 1");
  end

  arb_state_t      state_q, state_d;
  arb_state_t      winner;
  logic [XLEN-1:0] bus_adr_q, bus_adr_d;
  logic            bus_write_q, bus_write_d;
  logic            arb_en;
  logic            starve_fired;

  logic            bus_req, ifu_gnt, lsu_gnt, ifu_done, lsu_done, bus_owner;

  // A new owner is only chosen while idle or on the completing cycle of the current one.
  assign arb_en = (state_q == ARB_IDLE) || bus.BusDone;

  always_comb begin
    winner = ARB_IDLE;
    if ((state_q == ARB_IFU) && bus.IFUSpillLock && bus.IFUReq) begin
      winner = ARB_IFU;
    end else if ((state_q == ARB_LSU) && bus.LSUAtomicLock && bus.LSUReq) begin
      winner = ARB_LSU;
    end else if (starve_fired && bus.IFUReq) begin
      winner = ARB_IFU;
    end else if (bus.LSUReq) begin
      winner = ARB_LSU;
    end else if (bus.IFUReq) begin
      winner = ARB_IFU;
    end
  end

  always_comb begin
    state_d     = state_q;
    bus_adr_d   = bus_adr_q;
    bus_write_d = bus_write_q;
    bus_req     = (state_q != ARB_IDLE);
    ifu_gnt     = (state_q == ARB_IFU);
    lsu_gnt     = (state_q == ARB_LSU);
    bus_owner   = owner_of(state_q);
    ifu_done    = bus.BusDone && (state_q == ARB_IFU);
    lsu_done    = bus.BusDone && (state_q == ARB_LSU);
    if (arb_en) begin
      state_d = winner;
      // Address and write flag are captured only for a real winner; idle holds the last values.
      case (winner)
        ARB_IFU: begin
          bus_adr_d   = bus.IFUAdr;
          bus_write_d = 1'b0;
        end
        ARB_LSU: begin
          bus_adr_d   = bus.LSUAdr;
          bus_write_d = bus.LSUWrite;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ARB_IDLE;
      bus_adr_q   <= '0;
      bus_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_adr_q   <= bus_adr_d;
      bus_write_q <= bus_write_d;
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  logic starve_inc, starve_clr;

  assign starve_inc = bus.IFUReq && (state_q != ARB_IFU);
  assign starve_clr = arb_en && (winner == ARB_IFU);

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (starve_inc),
    .clr     (starve_clr),
    .fired   (starve_fired)
  );
`else
  assign starve_fired = 1'b0;
`endif

  assign bus.BusReq   = bus_req;
  assign bus.BusAdr   = bus_adr_q;
  assign bus.BusWrite = bus_write_q;
  assign bus.BusOwner = bus_owner;
  assign bus.IFUGnt   = ifu_gnt;
  assign bus.LSUGnt   = lsu_gnt;
  assign bus.IFUDone  = ifu_done;
  assign bus.LSUDone  = lsu_done;

endmodule

// File: doc/fetch_lsu_arbiter.md
# fetch_lsu_arbiter

Two-requester arbiter that shares the single bus interface between the IFU fetch path and the LSU. It sits between the IFU/LSU bus-request logic and the bus adapter. It keeps ownership locked across the two halves of a spilled instruction fetch and across LSU atomic sequences. An optional starvation guard bounds how long the IFU can wait behind a busy LSU.

## Interface
Parameters:
- XLEN, 64, address width.
- STARVE_LIMIT, 8, IFU wait cycles before forced IFU priority (≥1; used only with the guard).

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset_n  in  1  reset, synchronous, active-low.
- IFUReq  in  1  IFU requests a fetch transaction.
- IFUAdr  in  XLEN  IFU fetch address.
- IFUSpillLock  in  1  IFU needs a second, back-to-back fetch (second half of spill).
- IFUGnt  out  1  IFU owns the bus.
- IFUDone  out  1  IFU transaction complete (1-cycle pulse).
- LSUReq  in  1  LSU requests a transaction.
- LSUAdr  in  XLEN  LSU address.
- LSUWrite  in  1  LSU transaction is a write.
- LSUAtomicLock  in  1  LSU needs a follow-on transaction without losing ownership.
- LSUGnt  out  1  LSU owns the bus.
- LSUDone  out  1  LSU transaction complete (1-cycle pulse).
- BusReq  out  1  transaction active toward the bus.
- BusAdr  out  XLEN  registered address of the active transaction.
- BusWrite  out  1  registered write flag; always 0 for IFU.
- BusOwner  out  1  0 = IFU, 1 = LSU; valid while BusReq is high.
- BusDone  in  1  bus completes the current transaction (1-cycle pulse).

## Operation
- States: ARB_IDLE, ARB_IFU, ARB_LSU.
- Reset values: state ARB_IDLE, starvation count 0. All outputs are 0, including BusAdr.
- Arbitration runs in ARB_IDLE, and in a busy state on the cycle BusDone is high:
  - lock: if the current owner's lock input and Req are both high, the owner keeps the bus;
  - force: else if the guard has fired and IFUReq is high, IFU wins;
  - LSU: else if LSUReq is high, LSU wins;
  - IFU: else if IFUReq is high, IFU wins;
  - none: else go to ARB_IDLE.
- On each arbitration edge, the winner's address and write flag are captured into BusAdr and BusWrite. The state moves to the winner's busy state.
- In a busy state:
  - BusReq=1 and the owner's Gnt=1.
  - BusAdr and BusWrite stay stable until BusDone.
  - Requester inputs are ignored except at BusDone.
- BusDone in ARB_IDLE is ignored and must not produce a Done pulse.
- A lock input that is high while the owner's Req is low does not hold the bus; normal arbitration applies.
- Simultaneous IFUReq and LSUReq in ARB_IDLE: LSU wins, unless the guard has fired.
- If reset_n goes low mid-transaction, the block returns to ARB_IDLE next edge and drops BusReq with no Done pulse. The bus adapter is reset in the same cycle.

## Timing
- Request to ownership: Req high in ARB_IDLE at edge N gives BusReq, Gnt and BusAdr valid in cycle N+1.
- Done routing: IFUDone = BusDone & state==ARB_IFU and LSUDone = BusDone & state==ARB_LSU. Both are combinational, zero latency.
- Back-to-back: when BusDone is high in cycle N and a winner exists, the new transaction drives the bus in cycle N+1. There is no idle bubble.
- A spill therefore occupies two consecutive transactions with no LSU interleave.

## Configuration
- Macro: ARB_STARVE_GUARD_EN.
- When defined:
  - A counter of width $clog2(STARVE_LIMIT+1) increments on each cycle that IFUReq is high and the state is not ARB_IFU.
  - The counter saturates at STARVE_LIMIT and clears on the edge IFU is granted.
  - The guard fires when count == STARVE_LIMIT.
  - The lock rule still outranks the guard.
- When undefined: strict LSU priority, no counter, and the STARVE_LIMIT parameter is unused.

## Structure
- Shared package: enum arb_state_t {ARB_IDLE, ARB_IFU, ARB_LSU} and the owner encoding constants OWNER_IFU=0, OWNER_LSU=1.
- One sub-module, arb_starve_ctr: saturating counter with inc, clr and fired outputs. It is instantiated only under ARB_STARVE_GUARD_EN.

## Test plan
- Single IFU request: IFUReq=1, IFUAdr=0x1000 at edge 0 → cycle 1 shows BusReq=1, BusOwner=0, BusAdr=0x1000. BusDone at cycle 3 → IFUDone=1 in cycle 3, ARB_IDLE in cycle 4.
- Collision: IFUReq and LSUReq both high in ARB_IDLE → LSU granted first. On its BusDone, IFU is granted the next cycle with no bubble.
- Spill lock: IFU owns 0x1FFE with IFUSpillLock=1, IFUAdr switched to 0x2000, and LSUReq high → after BusDone, BusAdr=0x2000 and owner remains IFU. The LSU is granted only after the second BusDone.
- Atomic lock: LSUAtomicLock=1 with LSUReq held → two LSU transactions occur back-to-back while a pending IFUReq waits.
- Starvation (guard on, STARVE_LIMIT=4): LSUReq held high continuously and IFUReq high → IFU is granted at the first arbitration after its count reaches 4. With the guard off, IFU is never granted while LSUReq stays high.
- Reset mid-transaction: reset_n low during ARB_LSU → next cycle BusReq=0, LSUGnt=0, with no LSUDone pulse, even if BusDone is asserted.
